// File: rtl/dual_port_ram_ctl.sv
// True dual-port synchronous RAM with power-on clear sweep, read-valid strobes,
// 1/2-cycle read pipeline and write-collision arbitration. Optional: DPRAM_PARITY_EN.
module dual_port_ram_ctl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned WR_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en1,
  input  logic              en2,
  input  logic              we1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic              rvalid1,
  output logic              rvalid2,
  output logic              init_done,
  output logic              wr_collision,
  output logic              par_err1,
  output logic              par_err2
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef DPRAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("dual_port_ram_ctl: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              clearing;
  logic              running;

  logic [MEM_W-1:0]  mem [DEPTH];

  logic [1:0]              en_p, we_p, rd_p, wr_p;
  logic [1:0][ADDR_W-1:0]  addr_p;
  logic [1:0][DATA_W-1:0]  data_p;
  logic [1:0][DATA_W-1:0]  q_p;
  logic [1:0]              rv_p, pe_p;
  logic                    same_wr;

  always_comb begin
    en_p   = {en2, en1};
    we_p   = {we2, we1};
    addr_p = {addr2, addr1};
    data_p = {data2, data1};
    rd_p   = {2{running}} & en_p & ~we_p;
    wr_p   = {2{running}} & en_p & we_p;
    same_wr = wr_p[0] && wr_p[1] && (addr1 == addr2);
  end

  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef DPRAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (clearing) cnt <= cnt + 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == '1) state_nxt = RUN;
  end

  // FSM: outputs
  always_comb begin
    clearing  = (state == CLEAR);
    running   = (state == RUN);
    init_done = running;
  end

  // Port 1 wins a same-address double write; port 2's write is suppressed.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[cnt] <= '0;
    end else begin
      if (wr_p[1] && !same_wr) mem[addr2] <= encode(data2);
      if (wr_p[0])             mem[addr1] <= encode(data1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_collision <= 1'b0;
    else        wr_collision <= same_wr;
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [MEM_W-1:0]  rword;
    logic [DATA_W-1:0] s1_q;
    logic              s1_v, s1_pe;

    always_comb rword = mem[addr_p[p]];

    // Nonblocking read of the array gives read-first behaviour against the other port.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_q  <= '0;
        s1_v  <= 1'b0;
        s1_pe <= 1'b0;
      end else if (rd_p[p]) begin
        s1_q  <= rword[DATA_W-1:0];
        s1_v  <= 1'b1;
`ifdef DPRAM_PARITY_EN
        s1_pe <= ^rword;
`else
        s1_pe <= 1'b0;
`endif
      end else if (wr_p[p] && WR_MODE == 1) begin
        s1_q  <= data_p[p];
        s1_v  <= 1'b1;
        s1_pe <= 1'b0;
      end else begin
        s1_v  <= 1'b0;
        s1_pe <= 1'b0;
      end
    end

    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] s2_q;
      logic              s2_v, s2_pe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_q  <= '0;
          s2_v  <= 1'b0;
          s2_pe <= 1'b0;
        end else begin
          if (s1_v) s2_q <= s1_q;
          s2_v  <= s1_v;
          s2_pe <= s1_pe;
        end
      end

      assign q_p[p]  = s2_q;
      assign rv_p[p] = s2_v;
      assign pe_p[p] = s2_pe;
    end else begin : g_lat1
      assign q_p[p]  = s1_q;
      assign rv_p[p] = s1_v;
      assign pe_p[p] = s1_pe;
    end
  end

  assign q1      = q_p[0];
  assign q2      = q_p[1];
  assign rvalid1 = rv_p[0];
  assign rvalid2 = rv_p[1];
`ifdef DPRAM_PARITY_EN
  assign par_err1 = pe_p[0];
  assign par_err2 = pe_p[1];
`else
  assign par_err1 = 1'b0;
  assign par_err2 = 1'b0;
  logic unused_pe;
  assign unused_pe = ^pe_p;
`endif

endmodule

// File: tb/tb_dual_port_ram_ctl.sv
// Directed bench for dual_port_ram_ctl: instance A (latency 1, no-change) and
// instance B (latency 2, write-first) share the same stimulus.
module tb_dual_port_ram_ctl;

  logic       clk, rst_n;
  logic       en1, en2, we1, we2;
  logic [5:0] addr1, addr2;
  logic [7:0] data1, data2;

  logic [7:0] a_q1, a_q2, b_q1, b_q2;
  logic       a_rv1, a_rv2, b_rv1, b_rv2;
  logic       a_init, b_init, a_wc, b_wc;
  logic       a_pe1, a_pe2, b_pe1, b_pe2;

  int n_cmp = 0;
  int n_bad = 0;
  logic seen;

  dual_port_ram_ctl #(.DATA_W(8), .ADDR_W(6), .RD_LATENCY(1), .WR_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en1(en1), .en2(en2), .we1(we1), .we2(we2),
    .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
    .q1(a_q1), .q2(a_q2), .rvalid1(a_rv1), .rvalid2(a_rv2),
    .init_done(a_init), .wr_collision(a_wc), .par_err1(a_pe1), .par_err2(a_pe2)
  );

  dual_port_ram_ctl #(.DATA_W(8), .ADDR_W(6), .RD_LATENCY(2), .WR_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en1(en1), .en2(en2), .we1(we1), .we2(we2),
    .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
    .q1(b_q1), .q2(b_q2), .rvalid1(b_rv1), .rvalid2(b_rv2),
    .init_done(b_init), .wr_collision(b_wc), .par_err1(b_pe1), .par_err2(b_pe2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en1 = 0; en2 = 0; we1 = 0; we2 = 0;
  endtask

  task automatic op(input logic e1, input logic w1, input logic [5:0] a1, input logic [7:0] d1,
                    input logic e2, input logic w2, input logic [5:0] a2, input logic [7:0] d2);
    en1 = e1; we1 = w1; addr1 = a1; data1 = d1;
    en2 = e2; we2 = w2; addr2 = a2; data2 = d2;
    cyc();
    idle();
  endtask

  task automatic sweep(input int lim, output int n);
    n = 0;
    seen = 0;
    while (n < lim && !a_init) begin
      cyc();
      n++;
      seen = seen | a_rv1 | a_rv2 | b_rv1 | b_rv2 | a_wc | b_wc;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_q"},    {a_q1, a_q2, b_q1, b_q2}, 32'h0);
    check({tag, "_flags"}, {a_rv1, a_rv2, b_rv1, b_rv2, a_init, b_init, a_wc, b_wc,
                            a_pe1, a_pe2, b_pe1, b_pe2}, 32'h0);
  endtask

  logic [5:0] ra [4];
  logic [7:0] rd [4];

  initial begin
    int n;
    ra = '{6'h01, 6'h02, 6'h03, 6'h05};
    rd = '{8'h42, 8'h55, 8'h57, 8'h11};
    rst_n = 0;
    addr1 = '0; addr2 = '0; data1 = '0; data2 = '0;
    idle();
    repeat (3) cyc();
    check_zero("reset");

    // Release; port traffic during the sweep must be ignored.
    rst_n = 1;
    en1 = 1; we1 = 1; addr1 = 6'h1F; data1 = 8'hFF;
    en2 = 1; we2 = 1; addr2 = 6'h1F; data2 = 8'hEE;
    sweep(200, n);
    idle();
    check("sweep_len", n, 64);
    check("init_b", b_init, 1);
    check("sweep_quiet", seen, 0);

    op(1, 0, 6'h00, 8'h00, 1, 0, 6'h1F, 8'h00);
    check("rd0_a", {a_rv1, a_q1, a_rv2, a_q2}, {1'b1, 8'h00, 1'b1, 8'h00});
    cyc();
    check("rd0_b", {b_rv1, b_q1, b_rv2, b_q2}, {1'b1, 8'h00, 1'b1, 8'h00});
    check("rd0_a_pulse", {a_rv1, a_rv2}, 2'b00);
    op(1, 0, 6'h3F, 8'h00, 0, 0, 6'h00, 8'h00);
    check("rd3f_a", {a_rv1, a_q1}, {1'b1, 8'h00});
    cyc();

    // Independent writes, then crossed reads.
    op(1, 1, 6'h01, 8'h42, 1, 1, 6'h02, 8'h55);
    check("wr_nochange_a", {a_rv1, a_q1, a_rv2, a_q2}, {1'b0, 8'h00, 1'b0, 8'h00});
    check("wr_b_early", {b_rv1, b_rv2}, 2'b00);
    cyc();
    check("wr_first_b", {b_rv1, b_q1, b_rv2, b_q2}, {1'b1, 8'h42, 1'b1, 8'h55});
    op(1, 0, 6'h02, 8'h00, 1, 0, 6'h01, 8'h00);
    check("xrd_a", {a_rv1, a_q1, a_rv2, a_q2}, {1'b1, 8'h55, 1'b1, 8'h42});
    check("xrd_perr_a", {a_pe1, a_pe2}, 2'b00);
    cyc();
    check("xrd_b", {b_rv1, b_q1, b_rv2, b_q2}, {1'b1, 8'h55, 1'b1, 8'h42});
    check("xrd_a_pulse", {a_rv1, a_rv2}, 2'b00);

    // Read-first across ports.
    op(1, 1, 6'h03, 8'hAA, 0, 0, 6'h00, 8'h00);
    cyc();
    op(1, 1, 6'h03, 8'h57, 1, 0, 6'h03, 8'h00);
    check("rdfirst_a", {a_rv1, a_rv2, a_q2}, {1'b0, 1'b1, 8'hAA});
    cyc();
    check("rdfirst_b", {b_rv1, b_q1, b_rv2, b_q2}, {1'b1, 8'h57, 1'b1, 8'hAA});
    op(0, 0, 6'h00, 8'h00, 1, 0, 6'h03, 8'h00);
    check("rdafter_a", {a_rv2, a_q2}, {1'b1, 8'h57});
    cyc();

    // Double write to one address: port 1 wins, one-cycle flag.
    op(1, 1, 6'h05, 8'h11, 1, 1, 6'h05, 8'h22);
    check("coll_pulse", {a_wc, b_wc}, 2'b11);
    cyc();
    check("coll_drop", {a_wc, b_wc}, 2'b00);
    op(1, 0, 6'h05, 8'h00, 1, 0, 6'h05, 8'h00);
    check("coll_data", {a_q1, a_q2}, {8'h11, 8'h11});
    check("rdrd_noflag", a_wc, 0);
    cyc();

    // Back-to-back reads: A streams at latency 1, B at latency 2.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        en1 = 1; we1 = 0; addr1 = ra[i];
      end else begin
        idle();
      end
      cyc();
      check($sformatf("b2b_rv_a%0d", i), a_rv1, (i < 4));
      if (i < 4) check($sformatf("b2b_q_a%0d", i), a_q1, rd[i]);
      check($sformatf("b2b_rv_b%0d", i), b_rv1, (i >= 1 && i <= 4));
      if (i >= 1 && i <= 4) check($sformatf("b2b_q_b%0d", i), b_q1, rd[i-1]);
    end

    // Reset mid-run: outputs drop at once, then a full sweep clears the array.
    #2 rst_n = 0;
    #1 check_zero("rst_run");
    cyc();
    rst_n = 1;
    sweep(200, n);
    check("sweep2_len", n, 64);
    op(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00);
    check("cleared", {a_rv1, a_q1}, {1'b1, 8'h00});
    cyc();
    op(1, 1, 6'h01, 8'h42, 0, 0, 6'h00, 8'h00);
    op(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00);
    check("pre_rst_sweep_q", a_q1, 8'h42);

    // Reset mid-sweep restarts the count from address 0.
    #2 rst_n = 0;
    #1 check_zero("rst_run2");
    cyc();
    rst_n = 1;
    sweep(30, n);
    check("mid_sweep_low", {a_init, b_init}, 2'b00);
    #2 rst_n = 0;
    #1 check_zero("rst_sweep");
    cyc();
    rst_n = 1;
    sweep(200, n);
    check("sweep3_len", n, 64);

    op(1, 1, 6'h01, 8'h42, 0, 0, 6'h00, 8'h00);
    op(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00);
    check("par_ok", {a_rv1, a_q1, a_pe1}, {1'b1, 8'h42, 1'b0});
    cyc();
`ifdef DPRAM_PARITY_EN
    dut_a.mem[1] = dut_a.mem[1] ^ 9'h100;
    op(1, 0, 6'h01, 8'h00, 0, 0, 6'h00, 8'h00);
    check("par_err", {a_rv1, a_pe1}, 2'b11);
    cyc();
    check("par_err_pulse", a_pe1, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
